// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared types and constants for the 5-stage CPU pipeline control
//            blocks. Holds the hazard controller state encoding, the
//            register-ID width and the bundled stage-control word.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int REGID_W = 4;
  localparam logic [REGID_W-1:0] REG_ZERO = 4'd0;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DMEM_WAIT = 2'd1,
    ST_IMEM_WAIT = 2'd2
  } hz_state_t;

  // One bundle for the five stage enables and the two flushes.
  typedef struct packed {
    logic pc_write;
    logic fd_write;
    logic dx_write;
    logic xm_write;
    logic mw_write;
    logic fd_flush;
    logic dx_flush;
  } hz_ctrl_t;

  // Free-running pipeline: everything advances, nothing squashed.
  localparam hz_ctrl_t CTRL_RUN = '{
    pc_write: 1'b1, fd_write: 1'b1, dx_write: 1'b1, xm_write: 1'b1,
    mw_write: 1'b1, fd_flush: 1'b0, dx_flush: 1'b0
  };

  // Whole pipeline frozen (data-side miss).
  localparam hz_ctrl_t CTRL_FREEZE = '{
    pc_write: 1'b0, fd_write: 1'b0, dx_write: 1'b0, xm_write: 1'b0,
    mw_write: 1'b0, fd_flush: 1'b0, dx_flush: 1'b0
  };

  // Front end held, a bubble goes into X, back end keeps draining.
  localparam hz_ctrl_t CTRL_FRONT_STALL = '{
    pc_write: 1'b0, fd_write: 1'b0, dx_write: 1'b1, xm_write: 1'b1,
    mw_write: 1'b1, fd_flush: 1'b0, dx_flush: 1'b1
  };

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : hazard_detect
// Purpose  : Combinational load-use comparator. Flags when the instruction in
//            decode reads a register that the load in execute has not yet
//            produced and which forwarding cannot supply in time.
// Ports    : i_fd_rs/i_fd_rt      decode source register IDs
//            i_fd_uses_rs/_rt     decode instruction really reads the source
//            i_fd_is_store        decode is a store (rt is store data)
//            i_dx_memread         execute instruction is a load
//            i_dx_rd              execute destination register ID
//            o_load_use           one-bubble stall required
// Revision : 1.0 - initial release
// ============================================================================
module hazard_detect
  import cpu_pkg::*;
(
  input  logic [REGID_W-1:0] i_fd_rs,
  input  logic [REGID_W-1:0] i_fd_rt,
  input  logic               i_fd_uses_rs,
  input  logic               i_fd_uses_rt,
  input  logic               i_fd_is_store,
  input  logic               i_dx_memread,
  input  logic [REGID_W-1:0] i_dx_rd,
  output logic               o_load_use
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = i_fd_uses_rs && (i_fd_rs == i_dx_rd);
  // Store data is forwarded M->M, so a store's rt never needs the bubble.
  assign w_rt_hit = i_fd_uses_rt && !i_fd_is_store && (i_fd_rt == i_dx_rd);

  // r0 is hardwired zero and can never carry a dependency.
  assign o_load_use = i_dx_memread && (i_dx_rd != REG_ZERO) && (w_rs_hit || w_rt_hit);

endmodule : hazard_detect
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit
// Purpose  : Pipeline stall/flush controller. Generates stage write-enables
//            and flushes for load-use, taken branches and I/D cache misses,
//            and counts cycles in which the PC is held.
// Ports    : clk, rst                       clock, sync active-high reset
//            fd_*, dx_memread, dx_rd        load-use detection inputs
//            branch_taken                   branch resolved taken in X
//            imem_miss/imem_done            fetch miss level / done pulse
//            dmem_miss/dmem_done            data miss level / done pulse
//            pc/fd/dx/xm/mw_write           stage register enables
//            fd_flush, dx_flush             load NOP into fd / dx
//            stall_cycles                   saturating pc-hold counter
// Revision : 1.0 - initial release
// ============================================================================
module hazard_unit
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic [REGID_W-1:0] fd_rs,
  input  logic [REGID_W-1:0] fd_rt,
  input  logic               fd_uses_rs,
  input  logic               fd_uses_rt,
  input  logic               fd_is_store,
  input  logic               dx_memread,
  input  logic [REGID_W-1:0] dx_rd,
  input  logic               branch_taken,
  input  logic               imem_miss,
  input  logic               imem_done,
  input  logic               dmem_miss,
  input  logic               dmem_done,
  output logic               pc_write,
  output logic               fd_write,
  output logic               dx_write,
  output logic               xm_write,
  output logic               mw_write,
  output logic               fd_flush,
  output logic               dx_flush,
  output logic [CNT_W-1:0]   stall_cycles
);

  hz_state_t        r_st;
  logic             r_br_pend;
  logic [CNT_W-1:0] r_stall_cnt;

  hz_state_t        w_st_nxt;
  logic             w_br_pend_nxt;
  logic             w_load_use;
  logic             w_run_fetch;
  hz_ctrl_t         w_run_ctrl;
  hz_state_t        w_run_nxt;
  hz_ctrl_t         w_ctrl;

  hazard_detect u_detect (
    .i_fd_rs       (fd_rs),
    .i_fd_rt       (fd_rt),
    .i_fd_uses_rs  (fd_uses_rs),
    .i_fd_uses_rt  (fd_uses_rt),
    .i_fd_is_store (fd_is_store),
    .i_dx_memread  (dx_memread),
    .i_dx_rd       (dx_rd),
    .o_load_use    (w_load_use)
  );

  // Normal-flow rules, reused by RUN, the dmem_done cycle and the cycle a
  // fetch completes. In IMEM_WAIT the completing fetch is not a new miss.
  always_comb begin
    w_run_fetch = imem_miss && (r_st != ST_IMEM_WAIT);
    w_run_ctrl  = CTRL_RUN;
    w_run_nxt   = ST_RUN;
    if (branch_taken) begin
      w_run_ctrl.fd_flush = 1'b1;
      w_run_ctrl.dx_flush = 1'b1;
    end else if (w_load_use || w_run_fetch) begin
      w_run_ctrl = CTRL_FRONT_STALL;
    end
    // Load-use and fetch miss drive identical controls, so an outstanding
    // fetch can be tracked from this cycle even when load-use also fires.
    if (w_run_fetch && !branch_taken) begin
      w_run_nxt = ST_IMEM_WAIT;
    end
  end

  always_comb begin
    w_ctrl        = CTRL_RUN;
    w_st_nxt      = r_st;
    w_br_pend_nxt = r_br_pend;
    case (r_st)
      ST_RUN: begin
        if (dmem_miss) begin
          w_ctrl   = CTRL_FREEZE;
          w_st_nxt = ST_DMEM_WAIT;
        end else begin
          w_ctrl   = w_run_ctrl;
          w_st_nxt = w_run_nxt;
        end
      end
      ST_DMEM_WAIT: begin
        if (!dmem_done) begin
          w_ctrl = CTRL_FREEZE;
        end else begin
          w_ctrl   = w_run_ctrl;
          w_st_nxt = w_run_nxt;
        end
      end
      ST_IMEM_WAIT: begin
        if (dmem_miss) begin
          w_ctrl   = CTRL_FREEZE;
          w_st_nxt = ST_DMEM_WAIT;
        end else if (imem_done) begin
          w_st_nxt = ST_RUN;
          if (r_br_pend) begin
            // Word fetched from the pre-branch PC: drop it; PC already
            // points at the target.
            w_ctrl          = CTRL_RUN;
            w_ctrl.pc_write = 1'b0;
            w_ctrl.fd_flush = 1'b1;
            w_br_pend_nxt   = 1'b0;
          end else begin
            w_ctrl = w_run_ctrl;
          end
        end else begin
          w_ctrl = CTRL_FRONT_STALL;
          if (branch_taken) begin
            w_ctrl.pc_write = 1'b1;
            w_ctrl.fd_flush = 1'b1;
            w_br_pend_nxt   = 1'b1;
          end
        end
      end
      default: w_st_nxt = ST_RUN;
    endcase
    if (rst) begin
      w_ctrl = CTRL_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st        <= ST_RUN;
      r_br_pend   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_st      <= w_st_nxt;
      r_br_pend <= w_br_pend_nxt;
      if (!w_ctrl.pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign pc_write     = w_ctrl.pc_write;
  assign fd_write     = w_ctrl.fd_write;
  assign dx_write     = w_ctrl.dx_write;
  assign xm_write     = w_ctrl.xm_write;
  assign mw_write     = w_ctrl.mw_write;
  assign fd_flush     = w_ctrl.fd_flush;
  assign dx_flush     = w_ctrl.dx_flush;
  assign stall_cycles = r_stall_cnt;

endmodule : hazard_unit
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_unit
// Purpose  : Self-checking bench for hazard_unit. Directed scenarios followed
//            by randomized miss/branch/load-use traffic, compared each cycle
//            against a behavioural model of the stall/flush rules. A second
//            instance with a 4-bit counter exercises saturation.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_unit;

  localparam int M_RUN = 0;
  localparam int M_DW  = 1;
  localparam int M_IW  = 2;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] fd_rs, fd_rt, dx_rd;
  logic fd_uses_rs, fd_uses_rt, fd_is_store, dx_memread;
  logic branch_taken, imem_miss, imem_done, dmem_miss, dmem_done;

  logic pc_w, fd_w, dx_w, xm_w, mw_w, fd_f, dx_f;
  logic pc_w4, fd_w4, dx_w4, xm_w4, mw_w4, fd_f4, dx_f4;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int          m_mode;
  bit          m_brp;
  int unsigned m_cnt16, m_cnt4;
  // Model expectations for the current cycle
  bit [6:0]    e_ctrl;
  int          e_mode;
  bit          e_brp;

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt),
    .fd_is_store(fd_is_store), .dx_memread(dx_memread), .dx_rd(dx_rd),
    .branch_taken(branch_taken), .imem_miss(imem_miss), .imem_done(imem_done),
    .dmem_miss(dmem_miss), .dmem_done(dmem_done),
    .pc_write(pc_w), .fd_write(fd_w), .dx_write(dx_w), .xm_write(xm_w), .mw_write(mw_w),
    .fd_flush(fd_f), .dx_flush(dx_f), .stall_cycles(cnt16)
  );

  hazard_unit #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt),
    .fd_is_store(fd_is_store), .dx_memread(dx_memread), .dx_rd(dx_rd),
    .branch_taken(branch_taken), .imem_miss(imem_miss), .imem_done(imem_done),
    .dmem_miss(dmem_miss), .dmem_done(dmem_done),
    .pc_write(pc_w4), .fd_write(fd_w4), .dx_write(dx_w4), .xm_write(xm_w4), .mw_write(mw_w4),
    .fd_flush(fd_f4), .dx_flush(dx_f4), .stall_cycles(cnt4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural rules. Control vector order: pc,fd,dx,xm,mw,fd_flush,dx_flush.
  task automatic model_comb();
    bit lu, frozen, fetch;
    lu = dx_memread && (dx_rd != 4'd0) &&
         ((fd_uses_rs && fd_rs == dx_rd) ||
          (fd_uses_rt && !fd_is_store && fd_rt == dx_rd));
    e_ctrl = 7'b11111_00;
    e_mode = m_mode;
    e_brp  = m_brp;
    frozen = (m_mode != M_DW && dmem_miss) || (m_mode == M_DW && !dmem_done);
    if (rst) begin
      e_mode = M_RUN;
      e_brp  = 1'b0;
    end else if (frozen) begin
      e_ctrl = 7'b00000_00;
      e_mode = M_DW;
    end else if (m_mode == M_IW && !imem_done) begin
      e_ctrl = 7'b00111_01;
      if (branch_taken) begin
        e_ctrl = 7'b10111_11;
        e_brp  = 1'b1;
      end
    end else if (m_mode == M_IW && m_brp) begin
      e_ctrl = 7'b01111_10;
      e_brp  = 1'b0;
      e_mode = M_RUN;
    end else begin
      fetch = imem_miss && (m_mode != M_IW);
      if (branch_taken)      e_ctrl = 7'b11111_11;
      else if (lu || fetch)  e_ctrl = 7'b00111_01;
      e_mode = (fetch && !branch_taken) ? M_IW : M_RUN;
    end
  endtask

  // One clock cycle: predict, compare mid-cycle, advance model at the edge.
  task automatic step();
    model_comb();
    @(negedge clk);
    check("ctrl",  {25'd0, pc_w, fd_w, dx_w, xm_w, mw_w, fd_f, dx_f}, {25'd0, e_ctrl});
    check("ctrl4", {25'd0, pc_w4, fd_w4, dx_w4, xm_w4, mw_w4, fd_f4, dx_f4}, {25'd0, e_ctrl});
    check("cnt16", {16'd0, cnt16}, m_cnt16);
    check("cnt4",  {28'd0, cnt4}, m_cnt4);
    @(posedge clk);
    if (rst) begin
      m_cnt16 = 0;
      m_cnt4  = 0;
    end else if (!e_ctrl[6]) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15)     m_cnt4++;
    end
    m_mode = e_mode;
    m_brp  = e_brp;
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; fd_rs = 4'd0; fd_rt = 4'd0; dx_rd = 4'd0;
    fd_uses_rs = 1'b0; fd_uses_rt = 1'b0; fd_is_store = 1'b0; dx_memread = 1'b0;
    branch_taken = 1'b0; imem_miss = 1'b0; imem_done = 1'b0;
    dmem_miss = 1'b0; dmem_done = 1'b0;
  endtask

  // Random decode/execute registers biased towards matching IDs.
  task automatic rand_lu();
    dx_memread  = 1'($urandom_range(0, 1));
    dx_rd       = 4'($urandom_range(0, 15));
    fd_rs       = ($urandom_range(0, 1) == 1) ? dx_rd : 4'($urandom_range(0, 15));
    fd_rt       = ($urandom_range(0, 1) == 1) ? dx_rd : 4'($urandom_range(0, 15));
    fd_uses_rs  = 1'($urandom_range(0, 1));
    fd_uses_rt  = 1'($urandom_range(0, 1));
    fd_is_store = 1'($urandom_range(0, 1));
  endtask

  task automatic run_dmem(input int n, input bit imem_hold);
    for (int i = 0; i < n; i++) begin
      idle(); rand_lu(); dmem_miss = 1'b1; imem_miss = imem_hold; step();
    end
    idle(); rand_lu(); dmem_done = 1'b1; imem_miss = imem_hold;
    if (!imem_hold) branch_taken = ($urandom_range(0, 2) == 0);
    step();
  endtask

  // Fetch miss of n cycles (done in cycle n), optional branch at cycle br_at
  // and optional data miss of d_len cycles inserted after cycle d_at.
  task automatic run_imem(input int n, input int br_at, input int d_at, input int d_len);
    for (int c = 1; c <= n; c++) begin
      idle(); rand_lu(); imem_miss = 1'b1;
      branch_taken = (c == br_at);
      imem_done    = (c == n);
      step();
      if (c == d_at) run_dmem(d_len, 1'b1);
    end
    idle();
  endtask

  initial begin
    m_mode = M_RUN; m_brp = 1'b0; m_cnt16 = 0; m_cnt4 = 0;
    idle();
    rst = 1'b1;
    #1;
    step(); step();

    // Load-use: one bubble, counter reaches 1
    idle(); dx_memread = 1'b1; dx_rd = 4'd3; fd_rs = 4'd3; fd_uses_rs = 1'b1; step();
    check("lu_cnt", {16'd0, cnt16}, 32'd1);
    // Store data and r0 never stall
    idle(); dx_memread = 1'b1; dx_rd = 4'd3; fd_rt = 4'd3; fd_uses_rt = 1'b1; fd_is_store = 1'b1; step();
    idle(); dx_memread = 1'b1; dx_rd = 4'd0; fd_rs = 4'd0; fd_uses_rs = 1'b1; step();
    // Taken branch in RUN
    idle(); branch_taken = 1'b1; step();
    check("br_cnt", {16'd0, cnt16}, 32'd1);
    // Data miss: 4 frozen cycles then done
    for (int i = 0; i < 4; i++) begin idle(); dmem_miss = 1'b1; step(); end
    idle(); dmem_done = 1'b1; step();
    check("dmiss_cnt", {16'd0, cnt16}, 32'd5);
    // Branch during fetch miss: branch in cycle 2, done in cycle 5
    run_imem(5, 2, 0, 0);
    idle(); step();
    check("imiss_cnt", {16'd0, cnt16}, 32'd9);
    // Simultaneous misses: DMEM_WAIT first, then IMEM_WAIT
    run_dmem(3, 1'b1);
    run_imem(3, 0, 0, 0);
    idle(); step();
    // Reset in the middle of a data miss
    idle(); dmem_miss = 1'b1; step(); step();
    rst = 1'b1; step();
    rst = 1'b0; step();
    idle(); dmem_done = 1'b1; step();
    idle(); step();

    for (int it = 0; it < 250; it++) begin
      int kind, n;
      kind = $urandom_range(0, 5);
      n    = $urandom_range(3, 7);
      case (kind)
        0: begin idle(); rand_lu(); branch_taken = ($urandom_range(0, 3) == 0); step(); end
        1: run_dmem($urandom_range(1, 5), 1'b0);
        2: run_imem(n, ($urandom_range(0, 1) == 1) ? $urandom_range(2, n - 1) : 0, 0, 0);
        3: begin run_dmem($urandom_range(1, 4), 1'b1); run_imem($urandom_range(1, 4), 0, 0, 0); end
        4: run_imem(n, $urandom_range(2, n - 1), $urandom_range(1, n - 1), $urandom_range(1, 3));
        default: begin
          idle(); rand_lu(); dmem_miss = 1'($urandom_range(0, 1)); rst = 1'b1; step();
          idle(); step();
        end
      endcase
    end
    idle(); step();

    check("sat4", {28'd0, cnt4}, 32'd15);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule : tb_hazard_unit
`default_nettype wire
